// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
// Shared types and constants for the PS/2 frame receiver:
//   ps2_state_t  - frame deserialiser states
//   ERR_*        - error cause codes reported on err_type_o
//   FRAME_LEN    - bits per PS/2 frame (start + 8 data + parity + stop)
//   DATA_BITS    - payload bits per frame
//   parity_ok()  - odd-parity check over payload and parity bit
// ---------------------------------------------------------------------------
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_PARITY  = 2'b01;
    localparam logic [1:0] ERR_FRAME   = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam int FRAME_LEN = 11;
    localparam int DATA_BITS = FRAME_LEN - 3;

    // PS/2 uses odd parity: payload plus parity bit must hold an odd number of ones.
    function automatic logic parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// ---------------------------------------------------------------------------
// ps2_fifo
// Small synchronous byte FIFO with a registered head output.
// Ports:
//   i_clk, i_rst   - clock, synchronous active-high reset
//   i_push, i_din  - write request and data
//   i_pop          - read request (ignored while empty)
//   o_dout         - registered head byte (holds last value when empty)
//   o_full         - DEPTH entries stored
//   o_empty        - no entries stored
// A push while full is accepted only if a pop happens in the same cycle.
// ---------------------------------------------------------------------------
module ps2_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_push,
    input  logic [7:0] i_din,
    input  logic       i_pop,
    output logic [7:0] o_dout,
    output logic       o_full,
    output logic       o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_head;

    logic          w_do_pop;
    logic          w_do_push;
    logic [AW-1:0] w_rd_inc;
    logic [7:0]    w_head_next;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_dout    = r_head;

    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign w_rd_inc  = r_rd_ptr + AW'(1);

    // The head register must already show the next entry in the cycle after
    // a pop, so it is loaded from the slot behind the read pointer, or from
    // the incoming byte when that byte becomes the only entry.
    always_comb begin
        w_head_next = r_head;
        if (w_do_pop) begin
            if (r_count > CW'(1)) begin
                w_head_next = r_mem[w_rd_inc];
            end else if (w_do_push) begin
                w_head_next = i_din;
            end
        end else if (o_empty && w_do_push) begin
            w_head_next = i_din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            r_head <= w_head_next;
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= w_rd_inc;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ps2_frame_rx.sv
// ---------------------------------------------------------------------------
// ps2_frame_rx
// PS/2 keyboard receiver: synchronises and de-glitches the PS/2 lines,
// deserialises 11-bit frames, checks start/parity/stop, enforces a
// per-bit timeout and queues good scancodes in a FIFO.
// Ports:
//   wb_clk_i, wb_rst_i - clock, synchronous active-high reset
//   ps2_clk, ps2_data  - raw asynchronous PS/2 pins
//   code_o             - FIFO head scancode
//   code_valid_o       - FIFO non-empty
//   code_ack_i         - pop head byte
//   err_o              - one-cycle pulse on a rejected frame
//   err_type_o         - cause of the last error (01 parity, 10 stop, 11 timeout)
//   ovf_o              - sticky: a good byte was dropped on a full FIFO
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for a falling edge with data=0 (start bit)
// ST_DATA   | shifting in 8 payload bits, LSB first
// ST_PARITY | next falling edge carries the parity bit
// ST_STOP   | next falling edge carries the stop bit; frame is judged
// ---------------------------------------------------------------------------
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 50000,
    parameter int DEPTH      = 4
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code_o,
    output logic       code_valid_o,
    input  logic       code_ack_i,
    output logic       err_o,
    output logic [1:0] err_type_o,
    output logic       ovf_o
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic          r_clk_s1, r_clk_s2;
    logic          r_dat_s1, r_dat_s2;
    logic          r_clk_f;
    logic [7:0]    r_run;

    ps2_state_t    r_state;
    ps2_state_t    w_state_next;
    logic [7:0]    r_shreg;
    logic [2:0]    r_bitcnt;
    logic          r_par;
    logic [TW-1:0] r_to_cnt;
    logic          r_err;
    logic [1:0]    r_err_type;
    logic          r_ovf;

    logic          w_toggle;
    logic          w_event;
    logic          w_timeout;
    logic          w_push;
    logic          w_err_set;
    logic [1:0]    w_err_code;
    logic          w_full;
    logic          w_empty;
    logic          w_pop_eff;

    // Synchronisers and clock de-glitch filter. The filtered level only
    // follows the synchronised clock after FILTER_LEN differing samples
    // in a row; one agreeing sample restarts the run.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_clk_s1 <= 1'b1;
            r_clk_s2 <= 1'b1;
            r_dat_s1 <= 1'b1;
            r_dat_s2 <= 1'b1;
            r_clk_f  <= 1'b1;
            r_run    <= '0;
        end else begin
            r_clk_s1 <= ps2_clk;
            r_clk_s2 <= r_clk_s1;
            r_dat_s1 <= ps2_data;
            r_dat_s2 <= r_dat_s1;
            if (w_toggle) begin
                r_clk_f <= r_clk_s2;
                r_run   <= '0;
            end else if (r_clk_s2 != r_clk_f) begin
                r_run <= r_run + 8'd1;
            end else begin
                r_run <= '0;
            end
        end
    end

    assign w_toggle  = (r_clk_s2 != r_clk_f) && (r_run == 8'(FILTER_LEN - 1));
    // Event is the cycle in which the filtered clock is about to fall; the
    // synchronised data in that cycle is the bit value.
    assign w_event   = w_toggle & r_clk_f;
    assign w_timeout = (r_state != ST_IDLE) && !w_event &&
                       (r_to_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_timeout) begin
            w_state_next = ST_IDLE;
        end else if (w_event) begin
            case (r_state)
                ST_IDLE:   if (!r_dat_s2) w_state_next = ST_DATA;
                ST_DATA:   if (r_bitcnt == 3'(DATA_BITS - 1)) w_state_next = ST_PARITY;
                ST_PARITY: w_state_next = ST_STOP;
                ST_STOP:   w_state_next = ST_IDLE;
                default:   w_state_next = ST_IDLE;
            endcase
        end
    end

    // Parity is judged before the stop bit, so a frame with both faults
    // reports a parity error.
    always_comb begin
        w_push     = 1'b0;
        w_err_set  = 1'b0;
        w_err_code = ERR_NONE;
        if (w_timeout) begin
            w_err_set  = 1'b1;
            w_err_code = ERR_TIMEOUT;
        end else if (w_event && r_state == ST_STOP) begin
            if (!parity_ok(r_shreg, r_par)) begin
                w_err_set  = 1'b1;
                w_err_code = ERR_PARITY;
            end else if (!r_dat_s2) begin
                w_err_set  = 1'b1;
                w_err_code = ERR_FRAME;
            end else begin
                w_push = 1'b1;
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_shreg    <= '0;
            r_bitcnt   <= '0;
            r_par      <= 1'b0;
            r_to_cnt   <= '0;
            r_err      <= 1'b0;
            r_err_type <= ERR_NONE;
            r_ovf      <= 1'b0;
        end else begin
            r_err <= w_err_set;
            if (w_err_set) begin
                r_err_type <= w_err_code;
            end
            if (w_push && w_full && !w_pop_eff) begin
                r_ovf <= 1'b1;
            end

            if (r_state == ST_IDLE || w_event || w_timeout) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + TW'(1);
            end

            if (w_event) begin
                case (r_state)
                    ST_IDLE: begin
                        if (!r_dat_s2) begin
                            r_shreg  <= '0;
                            r_bitcnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        r_shreg  <= {r_dat_s2, r_shreg[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                    end
                    ST_PARITY: r_par <= r_dat_s2;
                    default:   r_par <= r_par;
                endcase
            end
        end
    end

    assign w_pop_eff = code_ack_i & ~w_empty;

    ps2_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (wb_clk_i),
        .i_rst   (wb_rst_i),
        .i_push  (w_push),
        .i_din   (r_shreg),
        .i_pop   (code_ack_i),
        .o_dout  (code_o),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign code_valid_o = ~w_empty;
    assign err_o        = r_err;
    assign err_type_o   = r_err_type;
    assign ovf_o        = r_ovf;

endmodule
